// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: op codes, instruction field layout, FSM states.
// The EXEC_WAIT state exists only when MUL_STALL_EN is defined.
package alu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS1_LSB = 7;
  localparam int unsigned RS2_LSB = 4;

  typedef enum logic [OP_W-1:0] {
    OP_OR  = 3'd0,
    OP_AND = 3'd1,
    OP_XOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_MUL = 3'd5,
    OP_NEQ = 3'd6,
    OP_LI  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
`ifdef MUL_STALL_EN
    ST_EXEC      = 2'd1,
    ST_EXEC_WAIT = 2'd2
`else
    ST_EXEC      = 2'd1
`endif
  } state_t;

  typedef struct packed {
    op_t               op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } instr_fields_t;

  // Register-operand view of an instruction; LI reuses rs1/rs2 bits as immediate.
  function automatic instr_fields_t decode(input logic [INSTR_W-1:0] ins);
    instr_fields_t f;
    f.op  = op_t'(ins[OP_LSB +: OP_W]);
    f.rd  = ins[RD_LSB +: REG_AW];
    f.rs1 = ins[RS1_LSB +: REG_AW];
    f.rs2 = ins[RS2_LSB +: REG_AW];
    return f;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, a debug read port, one synchronous write port.
// Entry 0 always reads zero and ignores writes; synchronous clear on rst.
module alu_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     i_raddr0,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_dbg_addr,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_dbg_data,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0   = (i_raddr0   == '0) ? '0 : r_regs[i_raddr0];
  assign o_rdata1   = (i_raddr1   == '0) ? '0 : r_regs[i_raddr1];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the combinational ALU: accepts an instruction, drives the ALU, writes back.
// Define MUL_STALL_EN to give MUL an extra EXEC_WAIT cycle with ALU inputs held.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned IMM_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_in0,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [OP_W-1:0]    alu_op_select,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               res_valid,
  output logic [REG_AW-1:0]  res_rd,
  output logic [DATA_W-1:0]  res_data,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int unsigned AW = $clog2(NREGS);

  state_t              r_state;
  op_t                 r_op;
  logic [REG_AW-1:0]   r_rd;
  logic [IMM_W-1:0]    r_imm;
  logic [DATA_W-1:0]   r_alu_in0;
  logic [DATA_W-1:0]   r_alu_in1;
  logic [OP_W-1:0]     r_alu_op;
  logic                r_res_valid;
  logic [REG_AW-1:0]   r_res_rd;
  logic [DATA_W-1:0]   r_res_data;

  instr_fields_t       w_dec;
  logic                w_accept;
  logic                w_done;
  logic [DATA_W-1:0]   w_result;
  logic [DATA_W-1:0]   w_rdata0;
  logic [DATA_W-1:0]   w_rdata1;

  assign w_dec       = decode(instr);
  assign instr_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept    = instr_valid && instr_ready;
  assign w_result    = (r_op == OP_LI) ? DATA_W'(r_imm) : alu_out;

  // Operands are read in IDLE straight from the offered instruction and held for EXEC.
  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_raddr0   (AW'(w_dec.rs1)),
    .i_raddr1   (AW'(w_dec.rs2)),
    .i_dbg_addr (AW'(dbg_addr)),
    .o_rdata0   (w_rdata0),
    .o_rdata1   (w_rdata1),
    .o_dbg_data (dbg_data),
    .i_we       (w_done),
    .i_waddr    (AW'(r_rd)),
    .i_wdata    (w_result)
  );

`ifdef MUL_STALL_EN
  assign w_done = ((r_state == ST_EXEC) && (r_op != OP_MUL)) || (r_state == ST_EXEC_WAIT);
`else
  assign w_done = (r_state == ST_EXEC);
`endif

  // Control FSM with instruction latch, ALU drive and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_OR;
      r_rd        <= '0;
      r_imm       <= '0;
      r_alu_in0   <= '0;
      r_alu_in1   <= '0;
      r_alu_op    <= '0;
      r_res_valid <= 1'b0;
      r_res_rd    <= '0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_EXEC;
            r_op    <= w_dec.op;
            r_rd    <= w_dec.rd;
            r_imm   <= instr[IMM_W-1:0];
            if (w_dec.op != OP_LI) begin
              r_alu_in0 <= w_rdata0;
              r_alu_in1 <= w_rdata1;
              r_alu_op  <= OP_W'(w_dec.op);
            end
          end
        end
        ST_EXEC: begin
`ifdef MUL_STALL_EN
          if (!w_done) r_state <= ST_EXEC_WAIT;
`endif
        end
`ifdef MUL_STALL_EN
        ST_EXEC_WAIT: begin
        end
`endif
        default: r_state <= ST_IDLE;
      endcase

      // Write-back edge: report the result and return the ALU drive to zero.
      if (w_done) begin
        r_state     <= ST_IDLE;
        r_res_valid <= 1'b1;
        r_res_rd    <= r_rd;
        r_res_data  <= w_result;
        r_alu_in0   <= '0;
        r_alu_in1   <= '0;
        r_alu_op    <= '0;
      end
    end
  end

  assign alu_in0       = r_alu_in0;
  assign alu_in1       = r_alu_in1;
  assign alu_op_select = r_alu_op;
  assign res_valid     = r_res_valid;
  assign res_rd        = r_res_rd;
  assign res_data      = r_res_data;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed and random checks of alu_issue_unit against a register-level reference model.
// Honours MUL_STALL_EN for the expected MUL latency.
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [2:0]  alu_op_select;
  logic [31:0] alu_out;
  logic        res_valid;
  logic [2:0]  res_rd;
  logic [31:0] res_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [8];
  logic [15:0] prog_q [$];

  alu_issue_unit #(.DATA_W(32), .NREGS(8), .IMM_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .alu_in0       (alu_in0),
    .alu_in1       (alu_in1),
    .alu_op_select (alu_op_select),
    .alu_out       (alu_out),
    .res_valid     (res_valid),
    .res_rd        (res_rd),
    .res_data      (res_data),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The ALU that sits beside the unit, as plain arithmetic.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a | b;
      3'd1:    return a & b;
      3'd2:    return a ^ b;
      3'd3:    return a + b;
      3'd4:    return a - b;
      3'd5:    return a * b;
      3'd6:    return (a != b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_op_select, alu_in0, alu_in1);

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] mk_li(input logic [2:0] rd, input logic [9:0] imm);
    return {3'd7, rd, imm};
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    return (a == 3'd0) ? 32'd0 : m_regs[a];
  endfunction

  function automatic logic [31:0] model_val(input logic [15:0] ins);
    if (ins[15:13] == 3'd7) return {22'd0, ins[9:0]};
    return alu_ref(ins[15:13], m_rd(ins[9:7]), m_rd(ins[6:4]));
  endfunction

  function automatic int lat_of(input logic [15:0] ins);
`ifdef MUL_STALL_EN
    if (ins[15:13] == 3'd5) return 3;
`endif
    return (ins[15:13] == 3'd5) ? 2 : 2;
  endfunction

  task automatic commit(input logic [15:0] ins, input logic [31:0] v);
    if (ins[12:10] != 3'd0) m_regs[ins[12:10]] = v;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dbg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // One instruction end to end with cycle-exact checks of EXEC drive and write-back.
  task automatic do_instr(input logic [15:0] ins, input string tag);
    logic [31:0] a, b, v;
    logic [2:0]  op;
    int          lat;
    op  = ins[15:13];
    a   = m_rd(ins[9:7]);
    b   = m_rd(ins[6:4]);
    v   = model_val(ins);
    lat = lat_of(ins);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, ".op_sel"}, 32'(alu_op_select), (op == 3'd7) ? 32'd0 : 32'(op));
    if (op != 3'd7) begin
      chk({tag, ".in0"}, alu_in0, a);
      chk({tag, ".in1"}, alu_in1, b);
    end
    chk({tag, ".early_res"}, 32'(res_valid), 32'd0);
    for (int c = 3; c <= lat; c++) begin
      @(negedge clk);
      chk({tag, ".wait_res"}, 32'(res_valid), 32'd0);
      chk({tag, ".wait_in0"}, alu_in0, a);
      chk({tag, ".wait_in1"}, alu_in1, b);
      chk({tag, ".wait_op"}, 32'(alu_op_select), 32'(op));
    end
    @(negedge clk);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".res_rd"}, 32'(res_rd), 32'(ins[12:10]));
    chk({tag, ".res_data"}, res_data, v);
    commit(ins, v);
    chk_dbg({tag, ".dbg_rd"}, ins[12:10], m_rd(ins[12:10]));
  endtask

  // Streams prog_q with instr_valid held high; checks accept spacing and every result.
  task automatic run_stream(input string tag, input int budget);
    logic [31:0] exp_d [$];
    logic [2:0]  exp_r [$];
    logic [31:0] v;
    int idx, n, accepts, last, cyc, gap;
    idx = 0; n = prog_q.size(); accepts = 0; last = 0; cyc = 0; gap = 2;
    while (cyc < budget && (idx < n || exp_d.size() > 0)) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        if (exp_d.size() == 0) begin
          chk({tag, ".spurious_res"}, 32'd1, 32'd0);
        end else begin
          chk({tag, ".res_rd"}, 32'(res_rd), 32'(exp_r[0]));
          chk({tag, ".res_data"}, res_data, exp_d[0]);
          void'(exp_d.pop_front());
          void'(exp_r.pop_front());
        end
      end
      if (idx < n) begin
        instr_valid = 1'b1;
        instr       = prog_q[idx];
        if (instr_ready) begin
          if (accepts > 0) chk({tag, ".gap"}, 32'(cyc - last), 32'(gap));
          v = model_val(instr);
          exp_d.push_back(v);
          exp_r.push_back(instr[12:10]);
          commit(instr, v);
          gap  = lat_of(instr);
          last = cyc;
          accepts++;
          idx++;
        end
      end else begin
        instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chk({tag, ".accepts"}, 32'(accepts), 32'(n));
    chk({tag, ".pending"}, 32'(exp_d.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 16'd0; dbg_addr = 3'd0;
    clear_model();

    // Reset held two cycles.
    @(negedge clk);
    chk("rst.ready0", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("rst.ready1", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready_after", 32'(instr_ready), 32'd1);
    chk("rst.res_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 8; i++) chk_dbg("rst.dbg", 3'(i), 32'd0);

    // Load immediates then ADD.
    do_instr(mk_li(3'd1, 10'd5), "li_r1");
    do_instr(mk_li(3'd2, 10'd3), "li_r2");
    do_instr(mk(3'd3, 3'd3, 3'd1, 3'd2), "add_r3");
    chk_dbg("add.dbg_r3", 3'd3, 32'd8);

    // SUB wrap, NEQ of equal, XOR.
    do_instr(mk(3'd4, 3'd4, 3'd2, 3'd1), "sub_r4");
    chk_dbg("sub.dbg_r4", 3'd4, 32'hFFFF_FFFE);
    do_instr(mk(3'd6, 3'd5, 3'd1, 3'd1), "neq_r5");
    chk_dbg("neq.dbg_r5", 3'd5, 32'd0);
    do_instr(mk(3'd2, 3'd6, 3'd1, 3'd2), "xor_r6");
    chk_dbg("xor.dbg_r6", 3'd6, 32'd6);

    // Write to r0 is reported but discarded.
    do_instr(mk_li(3'd0, 10'd7), "li_r0");
    chk_dbg("li_r0.dbg_r0", 3'd0, 32'd0);

    // Four back-to-back instructions with valid held high, including max immediate.
    prog_q = '{mk_li(3'd0, 10'd7), mk(3'd3, 3'd3, 3'd1, 3'd2),
               mk(3'd1, 3'd6, 3'd1, 3'd2), mk_li(3'd4, 10'h3FF)};
    run_stream("held4", 40);
    chk_dbg("held4.dbg_r4", 3'd4, 32'd1023);

    // MUL, with the stall-mode latency when enabled.
    do_instr(mk(3'd5, 3'd7, 3'd1, 3'd2), "mul_r7");
    chk_dbg("mul.dbg_r7", 3'd7, 32'd15);

    // Reset in the middle of an ADD.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mk(3'd3, 3'd3, 3'd1, 3'd2);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("midrst.in_exec", 32'(alu_op_select), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.res_valid_rst", 32'(res_valid), 32'd0);
    chk("midrst.ready_rst", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    clear_model();
    chk_dbg("midrst.dbg_r3", 3'd3, 32'd0);
    chk_dbg("midrst.dbg_r1", 3'd1, 32'd0);
    @(negedge clk);
    chk("midrst.res_valid_after", 32'(res_valid), 32'd0);
    do_instr(mk_li(3'd1, 10'd9), "midrst.li_r1");

    // Random program streamed against the model.
    prog_q = {};
    for (int i = 0; i < 8; i++) prog_q.push_back(mk_li(3'(i), 10'($urandom_range(0, 1023))));
    for (int i = 0; i < 60; i++) prog_q.push_back(16'($urandom_range(0, 65535)));
    run_stream("rand", 400);
    for (int i = 0; i < 8; i++) chk_dbg("rand.dbg", 3'(i), m_rd(3'(i)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
